// File: rtl/udp_panel_reader.sv
// udp_panel_reader
// Reads one row of one LED panel frame memory on request and streams it to
// the UDP core as a payload using the same layout the panel write path
// consumes: panel, row, then each pixel as high byte followed by low byte.
//
// Ports
//   clock            single clock, rising edge
//   reset            asynchronous, active-low
//   req_valid/ready  readback request handshake (ready only while idle)
//   req_panel        panel index to read
//   req_row          row to read (bits [5:0] address the RAM, all 8 echoed)
//   busy             high from request acceptance until the last byte leaves
//   ctrl_en          one-hot panel RAM read enable, one pulse per pixel
//   ctrl_addr        RAM read address {4'b0, row[5:0], x[5:0]}
//   ctrl_rdat        RAM read data, valid one cycle after ctrl_en
//   udp0_sink_*      byte stream towards the UDP core (valid/ready/data/last)
module udp_panel_reader #(
  parameter int NUM_PANELS = 9,
  parameter int ROW_PIXELS = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [7:0]            req_panel,
  input  logic [7:0]            req_row,
  output logic                  busy,
  output logic [NUM_PANELS-1:0] ctrl_en,
  output logic [15:0]           ctrl_addr,
  input  logic [23:0]           ctrl_rdat,
  output logic                  udp0_sink_valid,
  input  logic                  udp0_sink_ready,
  output logic [7:0]            udp0_sink_data,
  output logic                  udp0_sink_last
);

  localparam int XW = (ROW_PIXELS > 1) ? $clog2(ROW_PIXELS) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(ROW_PIXELS - 1);

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    FETCH,
    CAPTURE,
    PIX_HI,
    PIX_LO
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      panel_q, panel_d;
  logic [7:0]      row_q, row_d;
  logic [XW-1:0]   xPos_q, xPos_d;
  logic [15:0]     pixel_q, pixel_d;

  logic            panelValid;
  logic            isLastPixel;
  logic [5:0]      xExt;
  logic            unusedRdatBits;

  // Only the low 16 bits of the RAM word carry pixel data.
  assign unusedRdatBits = ^ctrl_rdat[23:16];

  // Out-of-range panels are still answered, but never touch any RAM.
  assign panelValid  = (panel_q < 8'(NUM_PANELS));
  assign isLastPixel = (xPos_q == X_LAST);

  // Zero-extend the pixel index into the 6-bit x field of the address.
  always_comb begin
    xExt = '0;
    xExt[XW-1:0] = xPos_q;
  end

  // State and datapath registers; everything clears on reset so a reset
  // mid-packet simply truncates the stream.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      panel_q <= '0;
      row_q   <= '0;
      xPos_q  <= '0;
      pixel_q <= '0;
    end else begin
      state_q <= state_d;
      panel_q <= panel_d;
      row_q   <= row_d;
      xPos_q  <= xPos_d;
      pixel_q <= pixel_d;
    end
  end

  // Next-state and output decode. All outputs are pure decodes of the
  // registered state, so valid/data/last are naturally held while stalled
  // and the RAM is read exactly once per pixel regardless of back-pressure.
  always_comb begin
    state_d         = state_q;
    panel_d         = panel_q;
    row_d           = row_q;
    xPos_d          = xPos_q;
    pixel_d         = pixel_q;
    req_ready       = 1'b0;
    busy            = 1'b1;
    ctrl_en         = '0;
    ctrl_addr       = '0;
    udp0_sink_valid = 1'b0;
    udp0_sink_data  = '0;
    udp0_sink_last  = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          panel_d = req_panel;
          row_d   = req_row;
          xPos_d  = '0;
          state_d = HDR0;
        end
      end

      HDR0: begin
        udp0_sink_valid = 1'b1;
        udp0_sink_data  = panel_q;
        if (udp0_sink_ready) state_d = HDR1;
      end

      HDR1: begin
        udp0_sink_valid = 1'b1;
        udp0_sink_data  = row_q;
        if (udp0_sink_ready) state_d = FETCH;
      end

      FETCH: begin
        for (int i = 0; i < NUM_PANELS; i++) begin
          ctrl_en[i] = (panel_q == 8'(i));
        end
        ctrl_addr = {4'b0000, row_q[5:0], xExt};
        state_d   = CAPTURE;
      end

      CAPTURE: begin
        pixel_d = panelValid ? ctrl_rdat[15:0] : 16'h0000;
        state_d = PIX_HI;
      end

      PIX_HI: begin
        udp0_sink_valid = 1'b1;
        udp0_sink_data  = pixel_q[15:8];
        if (udp0_sink_ready) state_d = PIX_LO;
      end

      PIX_LO: begin
        udp0_sink_valid = 1'b1;
        udp0_sink_data  = pixel_q[7:0];
        udp0_sink_last  = isLastPixel;
        if (udp0_sink_ready) begin
          if (isLastPixel) begin
            state_d = IDLE;
          end else begin
            xPos_d  = xPos_q + 1'b1;
            state_d = FETCH;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_udp_panel_reader.sv
// tb_udp_panel_reader
// Directed self-checking bench for udp_panel_reader. A behavioural panel RAM
// answers reads one cycle after ctrl_en with a known per-row pattern; every
// received byte, every fetch and the handshake hold behaviour are compared
// against hand-derived expectations.
module tb_udp_panel_reader;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_panel;
  logic [7:0]  req_row;
  logic        busy;
  logic [8:0]  ctrl_en;
  logic [15:0] ctrl_addr;
  logic [23:0] ctrl_rdat;
  logic        udp0_sink_valid;
  logic        udp0_sink_ready;
  logic [7:0]  udp0_sink_data;
  logic        udp0_sink_last;

  int checks = 0;
  int errors = 0;

  udp_panel_reader #(
    .NUM_PANELS(9),
    .ROW_PIXELS(64)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_panel      (req_panel),
    .req_row        (req_row),
    .busy           (busy),
    .ctrl_en        (ctrl_en),
    .ctrl_addr      (ctrl_addr),
    .ctrl_rdat      (ctrl_rdat),
    .udp0_sink_valid(udp0_sink_valid),
    .udp0_sink_ready(udp0_sink_ready),
    .udp0_sink_data (udp0_sink_data),
    .udp0_sink_last (udp0_sink_last)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Preloaded rows: panel 2 row 5, panel 0 row 0, panel 8 row 63.
  // Anything else reads back a filler value.
  function automatic logic [15:0] ramData(int p, logic [15:0] addr);
    logic [5:0] r;
    logic [5:0] x;
    r = addr[11:6];
    x = addr[5:0];
    if (p == 2 && r == 6'd5)  return 16'hA500 | {10'b0, x};
    if (p == 0 && r == 6'd0)  return 16'h3C00 | {10'b0, x};
    if (p == 8 && r == 6'd63) return 16'hC300 | {10'b0, x};
    return 16'h7777;
  endfunction

  // Panel RAM: one-cycle read latency; junk on the bus when not enabled and
  // junk in the unused upper byte.
  always @(posedge clock) begin
    ctrl_rdat <= 24'hEE5A5A;
    for (int p = 0; p < 9; p++) begin
      if (ctrl_en[p]) ctrl_rdat <= {8'hEE, ramData(p, ctrl_addr)};
    end
  end

  // Expected payload byte idx for a request; pixel x of a valid panel is
  // base + x, invalid panels read as zero.
  function automatic logic [7:0] expByte(logic [7:0] panel, logic [7:0] row,
                                         logic [15:0] base, int idx);
    logic [15:0] pix;
    if (idx == 0) return panel;
    if (idx == 1) return row;
    pix = (panel < 8'd9) ? base + 16'((idx - 2) / 2) : 16'h0000;
    return (((idx - 2) % 2) == 0) ? pix[15:8] : pix[7:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Issue one request from idle; returns at the falling edge of the first
  // busy cycle, where byte 0 must already be offered.
  task automatic applyStimulus(input logic [7:0] panel, input logic [7:0] row);
    @(negedge clock);
    req_valid = 1'b1;
    req_panel = panel;
    req_row   = row;
    checkOutput("reqReadyIdle", req_ready, 1);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    @(negedge clock);
    checkOutput("firstCycle", {busy, udp0_sink_valid, req_ready}, 3'b110);
  endtask

  // Collect one full packet starting at the current falling edge. Checks
  // every transferred byte, last, fetch enables/addresses, stall stability.
  // injectAt >= 0 pulses a foreign request for a few bytes from that index.
  task automatic receivePacket(input string tag, input logic [7:0] panel,
                               input logic [7:0] row, input logic [15:0] base,
                               input bit randomReady, input int injectAt);
    int         byteIdx;
    int         fetches;
    int         cycles;
    bit         stalled;
    bit         readyNext;
    logic [7:0] heldData;
    logic       heldLast;
    logic [8:0] expEn;
    byteIdx  = 0;
    fetches  = 0;
    cycles   = 0;
    stalled  = 1'b0;
    heldData = '0;
    heldLast = 1'b0;
    expEn    = (panel < 8'd9) ? (9'd1 << panel) : 9'd0;
    while (byteIdx < 130 && cycles < 3000) begin
      cycles++;
      if (ctrl_en != 9'd0) begin
        checkOutput({tag, ".en"}, ctrl_en, expEn);
        checkOutput({tag, ".addr"}, ctrl_addr, {4'b0, row[5:0], 6'(fetches)});
        fetches++;
      end
      if (udp0_sink_valid) begin
        checkOutput({tag, ".addrOff"}, ctrl_addr, 0);
        checkOutput({tag, ".busyRdy"}, {busy, req_ready}, 2'b10);
      end
      if (stalled) begin
        checkOutput({tag, ".holdValid"}, udp0_sink_valid, 1);
        checkOutput({tag, ".holdData"}, udp0_sink_data, heldData);
        checkOutput({tag, ".holdLast"}, udp0_sink_last, heldLast);
      end
      if (injectAt >= 0) begin
        if (byteIdx >= injectAt && byteIdx < injectAt + 6) begin
          req_valid = 1'b1;
          req_panel = 8'h07;
          req_row   = 8'h11;
        end else begin
          req_valid = 1'b0;
        end
      end
      readyNext = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
      udp0_sink_ready = readyNext;
      if (udp0_sink_valid && readyNext) begin
        checkOutput({tag, ".data"}, udp0_sink_data, expByte(panel, row, base, byteIdx));
        checkOutput({tag, ".last"}, udp0_sink_last, (byteIdx == 129) ? 1 : 0);
        byteIdx++;
        stalled = 1'b0;
      end else if (udp0_sink_valid) begin
        stalled  = 1'b1;
        heldData = udp0_sink_data;
        heldLast = udp0_sink_last;
      end
      @(negedge clock);
    end
    req_valid = 1'b0;
    udp0_sink_ready = 1'b1;
    checkOutput({tag, ".bytes"}, byteIdx, 130);
    checkOutput({tag, ".fetches"}, fetches, (panel < 8'd9) ? 64 : 0);
    checkOutput({tag, ".idleAfter"}, {req_ready, busy, udp0_sink_valid}, 3'b100);
  endtask

  initial begin
    reset           = 1'b0;
    req_valid       = 1'b0;
    req_panel       = '0;
    req_row         = '0;
    udp0_sink_ready = 1'b1;

    // Reset state.
    #3;
    checkOutput("rstValidLast", {udp0_sink_valid, udp0_sink_last}, 2'b00);
    checkOutput("rstData", udp0_sink_data, 0);
    checkOutput("rstCtrl", {ctrl_en, ctrl_addr}, 0);
    checkOutput("rstBusyReady", {busy, req_ready}, 2'b01);
    #20;
    @(negedge clock);
    reset = 1'b1;

    // Basic readback, ready held high.
    applyStimulus(8'd2, 8'd5);
    receivePacket("basic", 8'd2, 8'd5, 16'hA500, 1'b0, -1);

    // Same row under random back-pressure.
    applyStimulus(8'd2, 8'd5);
    receivePacket("bp", 8'd2, 8'd5, 16'hA500, 1'b1, -1);

    // Invalid panel: header echoed, zero pixels, no RAM enables.
    applyStimulus(8'd12, 8'd3);
    receivePacket("inval", 8'd12, 8'd3, 16'h0000, 1'b0, -1);

    // Back-to-back with req_valid held high.
    @(negedge clock);
    req_valid = 1'b1;
    req_panel = 8'd0;
    req_row   = 8'd0;
    @(posedge clock);
    #1;
    req_panel = 8'd8;
    req_row   = 8'd63;
    @(negedge clock);
    checkOutput("b2b.first", {busy, udp0_sink_valid, udp0_sink_data}, {2'b11, 8'h00});
    receivePacket("b2bA", 8'd0, 8'd0, 16'h3C00, 1'b0, -1);
    req_valid = 1'b1;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    @(negedge clock);
    checkOutput("b2b.second", {udp0_sink_valid, udp0_sink_data}, {1'b1, 8'h08});
    receivePacket("b2bB", 8'd8, 8'd63, 16'hC300, 1'b0, -1);

    // Foreign request pulsed mid-packet must be ignored.
    applyStimulus(8'd2, 8'd5);
    receivePacket("busyReq", 8'd2, 8'd5, 16'hA500, 1'b0, 40);

    // Reset during the fetch of pixel 20.
    applyStimulus(8'd2, 8'd5);
    udp0_sink_ready = 1'b1;
    repeat (82) @(negedge clock);
    checkOutput("rst.midEn", ctrl_en, 9'h004);
    checkOutput("rst.midAddr", ctrl_addr, 16'h0154);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("rst.asyncValid", {udp0_sink_valid, udp0_sink_last, udp0_sink_data}, 0);
    checkOutput("rst.asyncCtrl", {ctrl_en, ctrl_addr}, 0);
    checkOutput("rst.asyncBusy", {busy, req_ready}, 2'b01);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("rst.idle", {req_ready, busy, udp0_sink_valid}, 3'b100);
    applyStimulus(8'd2, 8'd5);
    receivePacket("afterRst", 8'd2, 8'd5, 16'hA500, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
